// File: rtl/bk_sd_ctl.sv
// bk_sd_ctl: backup-RAM <-> SD sector transfer controller.
// Each channel's backup RAM is enabled while a ROM download mounts a writable,
// non-empty image. When the download ends, the RAM is loaded from the image.
// Later it is loaded or saved on OSD request, one sector at a time.
// Optional feature macro: BK_AUTOSAVE_EN. When defined, core writes mark a
// channel dirty, and opening the OSD saves every dirty, enabled channel.
module bk_sd_ctl #(
    parameter int CH     = 2,
    parameter int MASK_W = 24,
    parameter int TMO    = 2**20
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 dl_active,
    input  logic [CH-1:0]        img_mounted,
    input  logic [CH-1:0]        img_readonly,
    input  logic [CH-1:0]        img_nz,
    input  logic [CH*MASK_W-1:0] ram_mask,
    input  logic [CH-1:0]        load_req,
    input  logic [CH-1:0]        save_req,
    input  logic [CH-1:0]        dirty_wr,
    input  logic                 osd_open,
    input  logic [CH-1:0]        sd_ack,
    output logic [CH-1:0]        sd_rd,
    output logic [CH-1:0]        sd_wr,
    output logic [31:0]          sd_lba,
    output logic [CH-1:0]        bk_ena,
    output logic                 loading,
    output logic                 busy,
    output logic                 err
);

    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1;
    localparam int TMO_W = $clog2(TMO) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    // Edge-detect history registers.
    logic          dl_prev_reg;
    logic [CH-1:0] load_prev_reg;
    logic [CH-1:0] save_prev_reg;
    logic [CH-1:0] ack_prev_reg;

    // Controller state.
    state_t            state_reg, state_next;
    logic [CH_W-1:0]   ch_reg, ch_next;
    logic              wr_reg, wr_next;
    logic [31:0]       lba_reg, lba_next;
    logic [TMO_W-1:0]  tmo_reg, tmo_next;
    logic [CH-1:0]     rd_reg, rd_next;
    logic [CH-1:0]     wrq_reg, wrq_next;
    logic              loading_reg, loading_next;
    logic              err_reg, err_next;
    logic [CH-1:0]     bk_ena_reg, bk_ena_next;

    // Pending job queues: one bit per channel and per job kind.
    logic [CH-1:0] pend_auto_reg, pend_auto_next;
    logic [CH-1:0] pend_load_reg, pend_load_next;
    logic [CH-1:0] pend_save_reg, pend_save_next;

    // Job picked this cycle; nonzero only in IDLE.
    logic [CH-1:0]   take_auto, take_load, take_save, take_asave;
    logic            found;
    logic [CH_W-1:0] sel_ch;
    logic            sel_wr;

    logic          dl_rise, dl_fall;
    logic [CH-1:0] load_rise, load_edge, save_edge;
    logic [CH-1:0] ack_rise, ack_fall;

    logic [MASK_W-1:0] mask_arr [CH];
    logic [CH-1:0]     mask_nz;
    logic [31:0]       last_lba;

    assign dl_rise   = dl_active & ~dl_prev_reg;
    assign dl_fall   = ~dl_active & dl_prev_reg;
    assign load_rise = load_req & ~load_prev_reg;
    assign load_edge = load_rise & bk_ena_reg;
    // When load and save rise together on one channel, the load wins.
    assign save_edge = save_req & ~save_prev_reg & bk_ena_reg & ~load_rise;
    assign ack_rise  = sd_ack & ~ack_prev_reg;
    assign ack_fall  = ~sd_ack & ack_prev_reg;

    for (genvar gi = 0; gi < CH; gi++) begin : g_mask
        assign mask_arr[gi] = ram_mask[gi*MASK_W +: MASK_W];
        assign mask_nz[gi]  = |mask_arr[gi];
    end

    // Index of the last sector of the active channel. It is the byte mask
    // shifted right by 9 (512-byte sectors).
    assign last_lba = 32'(mask_arr[ch_reg][MASK_W-1:9]);

`ifdef BK_AUTOSAVE_EN
    logic          osd_prev_reg;
    logic          osd_rise;
    logic [CH-1:0] dirty_reg, dirty_next;
    logic [CH-1:0] pend_asave_reg, pend_asave_next;

    assign osd_rise = osd_open & ~osd_prev_reg;

    // A save start clears dirty; a core write in that same cycle or later sets it again.
    always_comb begin
        dirty_next      = (dirty_reg & ~(take_save | take_asave)) | dirty_wr;
        pend_asave_next = (pend_asave_reg & ~take_asave)
                        | (osd_rise ? (dirty_reg & bk_ena_reg) : '0);
        if (dl_rise) begin
            pend_asave_next = '0;
        end
    end

    // Dirty flags, autosave queue and OSD edge history.
    always_ff @(posedge clk_sys) begin
        osd_prev_reg <= osd_open;
        if (!reset) begin
            dirty_reg      <= '0;
            pend_asave_reg <= '0;
        end else begin
            dirty_reg      <= dirty_next;
            pend_asave_reg <= pend_asave_next;
        end
    end
`else
    logic [CH-1:0] pend_asave_reg;
    logic          unused_autosave;

    assign pend_asave_reg  = '0;
    assign unused_autosave = &{1'b0, dirty_wr, osd_open, take_asave};
`endif

    // During a download, enable each channel that has a writable, non-empty image.
    always_comb begin
        bk_ena_next = bk_ena_reg;
        if (dl_rise) begin
            bk_ena_next = '0;
        end
        if (dl_active) begin
            for (int i = 0; i < CH; i++) begin
                if (img_mounted[i] && img_nz[i] && !img_readonly[i]) begin
                    bk_ena_next[i] = mask_nz[i];
                end
            end
        end
    end

    // Pick the next job, step the transfer FSM, and update the queues.
    always_comb begin
        state_next   = state_reg;
        ch_next      = ch_reg;
        wr_next      = wr_reg;
        lba_next     = lba_reg;
        tmo_next     = tmo_reg;
        rd_next      = rd_reg;
        wrq_next     = wrq_reg;
        loading_next = loading_reg;
        err_next     = err_reg;
        take_auto    = '0;
        take_load    = '0;
        take_save    = '0;
        take_asave   = '0;
        found        = 1'b0;
        sel_ch       = '0;
        sel_wr       = 1'b0;

        // Priority: auto-load, load, save, autosave; lowest channel first.
        if (state_reg == ST_IDLE && !dl_rise) begin
            for (int i = 0; i < CH; i++) begin
                if (!found && pend_auto_reg[i]) begin
                    found = 1'b1; sel_ch = CH_W'(i); sel_wr = 1'b0; take_auto[i] = 1'b1;
                end
            end
            for (int i = 0; i < CH; i++) begin
                if (!found && pend_load_reg[i]) begin
                    found = 1'b1; sel_ch = CH_W'(i); sel_wr = 1'b0; take_load[i] = 1'b1;
                end
            end
            for (int i = 0; i < CH; i++) begin
                if (!found && pend_save_reg[i]) begin
                    found = 1'b1; sel_ch = CH_W'(i); sel_wr = 1'b1; take_save[i] = 1'b1;
                end
            end
            for (int i = 0; i < CH; i++) begin
                if (!found && pend_asave_reg[i]) begin
                    found = 1'b1; sel_ch = CH_W'(i); sel_wr = 1'b1; take_asave[i] = 1'b1;
                end
            end
        end

        case (state_reg)
            ST_IDLE: begin
                if (found) begin
                    state_next      = ST_REQ;
                    ch_next         = sel_ch;
                    wr_next         = sel_wr;
                    lba_next        = '0;
                    tmo_next        = '0;
                    rd_next         = '0;
                    wrq_next        = '0;
                    rd_next[sel_ch] = ~sel_wr;
                    wrq_next[sel_ch] = sel_wr;
                    loading_next    = ~sel_wr;
                end
            end
            ST_REQ: begin
                if (ack_rise[ch_reg]) begin
                    rd_next    = '0;
                    wrq_next   = '0;
                    state_next = ST_XFER;
                end else if (tmo_reg == TMO_LAST) begin
                    // The card never answered: give up on this job.
                    rd_next      = '0;
                    wrq_next     = '0;
                    loading_next = 1'b0;
                    err_next     = 1'b1;
                    state_next   = ST_IDLE;
                end else begin
                    tmo_next = tmo_reg + TMO_W'(1);
                end
            end
            ST_XFER: begin
                if (ack_fall[ch_reg]) begin
                    if (lba_reg >= last_lba) begin
                        loading_next = 1'b0;
                        err_next     = 1'b0;
                        state_next   = ST_IDLE;
                    end else begin
                        lba_next         = lba_reg + 32'd1;
                        tmo_next         = '0;
                        rd_next          = '0;
                        wrq_next         = '0;
                        rd_next[ch_reg]  = ~wr_reg;
                        wrq_next[ch_reg] = wr_reg;
                        state_next       = ST_REQ;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        pend_auto_next = (pend_auto_reg & ~take_auto) | (dl_fall ? bk_ena_reg : '0);
        pend_load_next = (pend_load_reg & ~take_load) | load_edge;
        pend_save_next = (pend_save_reg & ~take_save) | save_edge;

        // A new download invalidates any RAM contents: stop everything at once.
        if (dl_rise) begin
            state_next     = ST_IDLE;
            rd_next        = '0;
            wrq_next       = '0;
            loading_next   = 1'b0;
            pend_auto_next = '0;
            pend_load_next = '0;
            pend_save_next = '0;
        end
    end

    // Edge history follows the inputs even in reset, so no edge is seen at reset release.
    always_ff @(posedge clk_sys) begin
        dl_prev_reg   <= dl_active;
        load_prev_reg <= load_req;
        save_prev_reg <= save_req;
        ack_prev_reg  <= sd_ack;
    end

    // Controller state registers.
    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            ch_reg        <= '0;
            wr_reg        <= 1'b0;
            lba_reg       <= '0;
            tmo_reg       <= '0;
            rd_reg        <= '0;
            wrq_reg       <= '0;
            loading_reg   <= 1'b0;
            err_reg       <= 1'b0;
            bk_ena_reg    <= '0;
            pend_auto_reg <= '0;
            pend_load_reg <= '0;
            pend_save_reg <= '0;
        end else begin
            state_reg     <= state_next;
            ch_reg        <= ch_next;
            wr_reg        <= wr_next;
            lba_reg       <= lba_next;
            tmo_reg       <= tmo_next;
            rd_reg        <= rd_next;
            wrq_reg       <= wrq_next;
            loading_reg   <= loading_next;
            err_reg       <= err_next;
            bk_ena_reg    <= bk_ena_next;
            pend_auto_reg <= pend_auto_next;
            pend_load_reg <= pend_load_next;
            pend_save_reg <= pend_save_next;
        end
    end

    // Requests are masked by reset itself. They drop in the reset cycle, not one later.
    assign sd_rd   = rd_reg & {CH{reset}};
    assign sd_wr   = wrq_reg & {CH{reset}};
    assign sd_lba  = lba_reg;
    assign bk_ena  = bk_ena_reg;
    assign loading = loading_reg;
    assign busy    = (state_reg != ST_IDLE);
    assign err     = err_reg;

endmodule

// File: tb/tb_bk_sd_ctl.sv
// Testbench for bk_sd_ctl. A scoreboard holds the expected sector requests.
// A monitor compares each new request against it. A card model acknowledges
// the requests.
module tb_bk_sd_ctl;

    localparam int CH     = 2;
    localparam int MASK_W = 24;
    localparam int TMO    = 16;

    logic                 clk_sys = 1'b0;
    logic                 reset;
    logic                 dl_active;
    logic [CH-1:0]        img_mounted, img_readonly, img_nz;
    logic [CH*MASK_W-1:0] ram_mask;
    logic [CH-1:0]        load_req, save_req, dirty_wr;
    logic                 osd_open;
    logic [CH-1:0]        sd_ack;
    logic [CH-1:0]        sd_rd, sd_wr;
    logic [31:0]          sd_lba;
    logic [CH-1:0]        bk_ena;
    logic                 loading, busy, err;

    logic ack_en;
    int   n_checks = 0;
    int   n_fail   = 0;

    typedef struct packed {
        logic [CH-1:0] rd;
        logic [CH-1:0] wr;
        logic [31:0]   lba;
        logic          ld;
    } txn_t;

    txn_t expq[$];

    bk_sd_ctl #(.CH(CH), .MASK_W(MASK_W), .TMO(TMO)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .dl_active   (dl_active),
        .img_mounted (img_mounted),
        .img_readonly(img_readonly),
        .img_nz      (img_nz),
        .ram_mask    (ram_mask),
        .load_req    (load_req),
        .save_req    (save_req),
        .dirty_wr    (dirty_wr),
        .osd_open    (osd_open),
        .sd_ack      (sd_ack),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .sd_lba      (sd_lba),
        .bk_ena      (bk_ena),
        .loading     (loading),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Queue the sectors 0..nsec-1 that a job on channel ch is expected to request.
    task automatic push_job(input int ch, input bit wr, input int nsec);
        txn_t t;
        for (int l = 0; l < nsec; l++) begin
            t     = '0;
            t.lba = 32'(l);
            t.ld  = ~wr;
            if (wr) t.wr[ch] = 1'b1;
            else    t.rd[ch] = 1'b1;
            expq.push_back(t);
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (!(expq.size() == 0 && !busy) && k < 3000) begin
            @(negedge clk_sys);
            k++;
        end
        repeat (6) @(negedge clk_sys);
        check({name, "_pending"}, 64'(expq.size()), 0);
        check({name, "_busy"}, busy, 0);
    endtask

    // Monitor: every new sector request must match the head of the scoreboard.
    initial begin : monitor
        logic [CH-1:0] req_prev;
        txn_t          e;
        req_prev = '0;
        forever begin
            @(negedge clk_sys);
            if (((sd_rd | sd_wr) & ~req_prev) != '0) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_req: got rd=%b wr=%b lba=%0d, expected none", sd_rd, sd_wr, sd_lba);
                end else begin
                    e = expq.pop_front();
                    check("req_rd", sd_rd, e.rd);
                    check("req_wr", sd_wr, e.wr);
                    check("req_lba", sd_lba, e.lba);
                    check("req_loading", loading, e.ld);
                    $display("txn rd=%b wr=%b lba=%0d loading=%0b", sd_rd, sd_wr, sd_lba, loading);
                end
            end
            req_prev = sd_rd | sd_wr;
        end
    end

    // Card model: acknowledges each request, then releases ack a little later.
    initial begin : responder
        int c;
        forever begin
            @(negedge clk_sys);
            if (ack_en && ((sd_rd | sd_wr) != '0) && sd_ack == '0) begin
                c = 0;
                for (int i = CH - 1; i >= 0; i--) if (sd_rd[i] || sd_wr[i]) c = i;
                @(negedge clk_sys);
                sd_ack[c] = 1'b1;
                for (int k = 0; k < 50 && (sd_rd[c] || sd_wr[c]); k++) @(negedge clk_sys);
                repeat (2) @(negedge clk_sys);
                sd_ack[c] = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int k;
        reset = 1'b0; dl_active = 1'b0; img_mounted = '0; img_readonly = '0; img_nz = '0;
        ram_mask = {24'h0007FF, 24'h001FFF};
        load_req = '0; save_req = '0; dirty_wr = '0; osd_open = 1'b0; sd_ack = '0; ack_en = 1'b1;
        repeat (4) @(negedge clk_sys);
        check("rst_sd_rd", sd_rd, 0);
        check("rst_sd_wr", sd_wr, 0);
        check("rst_sd_lba", sd_lba, 0);
        check("rst_bk_ena", bk_ena, 0);
        check("rst_loading", loading, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk_sys);

        // Download with both channels mounted, then auto-load: ch0 LBA 0..15, ch1 LBA 0..3.
        dl_active = 1'b1; img_nz = 2'b11; img_mounted = 2'b11;
        repeat (3) @(negedge clk_sys);
        img_mounted = '0;
        @(negedge clk_sys);
        check("dl_bk_ena", bk_ena, 2'b11);
        check("dl_busy", busy, 0);
        push_job(0, 0, 16);
        push_job(1, 0, 4);
        dl_active = 1'b0;
        wait_idle("autoload");
        check("autoload_loading", loading, 0);

        // Manual save of channel 1: write LBA 0..3.
        push_job(1, 1, 4);
        save_req = 2'b10; @(negedge clk_sys); save_req = '0;
        wait_idle("save1");
        check("save1_err", err, 0);

        // Load and save rise together on ch0; a ch1 save arrives mid-load.
        push_job(0, 0, 16);
        load_req = 2'b01; save_req = 2'b01; @(negedge clk_sys); load_req = '0; save_req = '0;
        k = 0;
        while (!(sd_rd[0] && sd_lba == 32'd3) && k < 500) begin @(negedge clk_sys); k++; end
        check("mid_load_reached", 64'(k < 500), 1);
        push_job(1, 1, 4);
        save_req = 2'b10; @(negedge clk_sys); save_req = '0;
        wait_idle("load_then_save");

        // No acknowledge: the request times out after TMO cycles.
        ack_en = 1'b0;
        push_job(1, 1, 1);
        save_req = 2'b10; @(negedge clk_sys); save_req = '0;
        k = 0;
        while (!sd_wr[1] && k < 50) begin @(negedge clk_sys); k++; end
        k = 0;
        while (sd_wr[1] && k < 100) begin @(negedge clk_sys); k++; end
        check("tmo_cycles", 64'(k), 16);
        check("tmo_err", err, 1);
        check("tmo_busy", busy, 0);
        check("tmo_sd_wr", sd_wr, 0);
        ack_en = 1'b1;
        push_job(1, 1, 4);
        save_req = 2'b10; @(negedge clk_sys); save_req = '0;
        wait_idle("save_after_tmo");
        check("err_cleared", err, 0);

        // Core write, then the OSD opens: ch0 is saved only if autosave is built in.
`ifdef BK_AUTOSAVE_EN
        push_job(0, 1, 16);
`endif
        dirty_wr = 2'b01; @(negedge clk_sys); dirty_wr = '0;
        repeat (3) @(negedge clk_sys);
        osd_open = 1'b1;
        repeat (3) @(negedge clk_sys);
        osd_open = 1'b0;
        wait_idle("autosave");

        // A download starts at LBA 5 of a load: abort at once.
        push_job(0, 0, 6);
        load_req = 2'b01; @(negedge clk_sys); load_req = '0;
        k = 0;
        while (!(sd_rd[0] && sd_lba == 32'd5) && k < 500) begin @(negedge clk_sys); k++; end
        check("abort_lba5_reached", 64'(k < 500), 1);
        dl_active = 1'b1;
        @(negedge clk_sys);
        check("abort_sd_rd", sd_rd, 0);
        check("abort_loading", loading, 0);
        check("abort_bk_ena", bk_ena, 0);
        check("abort_busy", busy, 0);
        repeat (20) @(negedge clk_sys);
        dl_active = 1'b0;
        repeat (10) @(negedge clk_sys);
        check("abort_pending", 64'(expq.size()), 0);
        check("abort_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
